// File: rtl/acc_buffer.sv
// acc_buffer: multi-lane, multi-row output accumulator for the systolic array.
// Fills DEPTH rows of LANES signed values in one or more passes. The first pass
// overwrites each row. Later passes add into the row with signed saturation.
// After the final pass the buffer drains rows 0..DEPTH-1 on a valid/ready stream.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-low reset
//   clear             synchronous abort back to FILL (memory contents kept)
//   in_valid/in_ready input beat handshake (in_ready only in FILL)
//   in_data           LANES x DATA_W, lane k at [k*DATA_W +: DATA_W]
//   in_last           beat belongs to final pass (sampled on row DEPTH-1 only)
//   out_valid/ready   drain handshake (out_valid only in DRAIN)
//   out_data, out_row drained row contents (LANES x ACC_W) and its index
//   full              buffer is draining
//   overflow          sticky saturation flag, cleared at drain end/clear/reset

// Per-lane next-value datapath: overwrite on first pass, saturating add after.
module acc_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              first_pass,
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] din,
  output logic [ACC_W-1:0]  nxt,
  output logic              sat
);
  // One guard bit: the sum of two ACC_W-bit signed values fits in ACC_W+1.
  logic [ACC_W:0] din_x, acc_x, sum;

  always_comb begin
    din_x = {{(ACC_W+1-DATA_W){din[DATA_W-1]}}, din};
    acc_x = first_pass ? '0 : {acc[ACC_W-1], acc};
    sum   = din_x + acc_x;
    sat   = 1'b0;
    nxt   = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat = 1'b1;
      nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
endmodule

module acc_buffer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int DEPTH  = 4,
  parameter int LANES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACC_W-1:0]    out_data,
  output logic [$clog2(DEPTH)-1:0]  out_row,
  output logic                      full,
  output logic                      overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);

  typedef enum logic {FILL, DRAIN} state_t;
  typedef logic [LANES-1:0][ACC_W-1:0] row_t;

  state_t                  state, state_nxt;
  row_t [DEPTH-1:0]        mem;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic                    first_pass;
  row_t                    lane_nxt;
  logic [LANES-1:0]        lane_sat;
  logic                    wr_beat, rd_xfer, wr_last, rd_last;

  assign wr_beat = in_valid && in_ready;
  assign rd_xfer = out_valid && out_ready;
  assign wr_last = (wr_ptr == LAST);
  assign rd_last = (rd_ptr == LAST);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    acc_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .first_pass (first_pass),
      .acc        (mem[wr_ptr][k]),
      .din        (in_data[k*DATA_W +: DATA_W]),
      .nxt        (lane_nxt[k]),
      .sat        (lane_sat[k])
    );
    assign out_data[k*ACC_W +: ACC_W] = mem[rd_ptr][k];
  end

  assign out_row = rd_ptr;

  always_comb begin
    state_nxt = state;
    in_ready  = (state == FILL);
    out_valid = (state == DRAIN);
    full      = (state == DRAIN);
    case (state)
      FILL:  if (wr_beat && wr_last && in_last) state_nxt = DRAIN;
      DRAIN: if (rd_xfer && rd_last)            state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      first_pass <= 1'b1;
      overflow   <= 1'b0;
      mem        <= '0;
    end else if (clear) begin
      // Rows keep stale data; first_pass=1 guarantees they are overwritten.
      state      <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      first_pass <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_beat) begin
        mem[wr_ptr] <= lane_nxt;
        if (|lane_sat) overflow <= 1'b1;
        wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        if (wr_last && !in_last) first_pass <= 1'b0;
        if (wr_last && in_last)  rd_ptr     <= '0;
      end
      if (rd_xfer) begin
        if (rd_last) begin
          rd_ptr     <= '0;
          wr_ptr     <= '0;
          first_pass <= 1'b1;
          overflow   <= 1'b0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_acc_buffer.sv
module tb_acc_buffer;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 9;
  localparam int DEPTH  = 4;
  localparam int LANES  = 2;

  logic                     clk = 1'b0;
  logic                     reset, clear, in_valid, in_ready, in_last;
  logic [LANES*DATA_W-1:0]  in_data;
  logic                     out_valid, out_ready, full, overflow;
  logic [LANES*ACC_W-1:0]   out_data;
  logic [1:0]               out_row;

  acc_buffer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int d0; int d1; } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int lane(input int k);
    logic [ACC_W-1:0] v;
    v = out_data[k*ACC_W +: ACC_W];
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted drain row is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_row: got row %0d with no expected entry", out_row);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("drain_row", int'(out_row), e.row);
        chk("drain_lane0", lane(0), e.d0);
        chk("drain_lane1", lane(1), e.d1);
      end
    end
  end

  task automatic beat(input int d0, input int d1, input bit last);
    in_valid = 1'b1;
    in_data  = {8'(d1), 8'(d0)};
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pass_same(input int d0, input int d1, input bit last);
    for (int r = 0; r < DEPTH; r++) beat(d0, d1, last && (r == DEPTH-1));
  endtask

  task automatic expect_rows(input int d0, input int d1);
    for (int r = 0; r < DEPTH; r++) q.push_back('{r, d0, d1});
  endtask

  task automatic drain_wait(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d rows outstanding, expected 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_row0_lane0", lane(0), 0);
    chk("rst_row0_lane1", lane(1), 0);

    // 1: single pass
    q.push_back('{0, 1, 2}); q.push_back('{1, 3, 4});
    q.push_back('{2, 5, 6}); q.push_back('{3, 7, 8});
    beat(1, 2, 0); beat(3, 4, 0); beat(5, 6, 0); beat(7, 8, 1);
    chk("t1_full", int'(full), 1);
    chk("t1_in_ready", int'(in_ready), 0);
    drain_wait("t1");
    chk("t1_back_to_fill", int'(in_ready), 1);
    chk("t1_full_end", int'(full), 0);

    // 2: three accumulating passes
    expect_rows(30, -9);
    pass_same(10, -3, 0); pass_same(10, -3, 0); pass_same(10, -3, 1);
    chk("t2_overflow", int'(overflow), 0);
    drain_wait("t2");

    // 3: saturation; 127*3 clamps to 255 and -128*3 clamps to -256
    expect_rows(255, -256);
    out_ready = 1'b0;
    pass_same(127, -128, 0); pass_same(127, -128, 0);
    chk("t3_no_ovf_yet", int'(overflow), 0);
    pass_same(127, -128, 1);
    chk("t3_full", int'(full), 1);
    chk("t3_overflow_drain", int'(overflow), 1);
    out_ready = 1'b1;
    drain_wait("t3");
    chk("t3_overflow_end", int'(overflow), 0);

    // 4: backpressure at row 1
    q.push_back('{0, 11, 12}); q.push_back('{1, 13, 14});
    q.push_back('{2, 15, 16}); q.push_back('{3, 17, 18});
    beat(11, 12, 0); beat(13, 14, 0); beat(15, 16, 0); beat(17, 18, 1);
    @(posedge clk); #1;            // row 0 transferred
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'hA5A5;
      @(posedge clk); #1;
      chk("t4_row_hold", int'(out_row), 1);
      chk("t4_lane0_hold", lane(0), 13);
      chk("t4_lane1_hold", lane(1), 14);
      chk("t4_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain_wait("t4");

    // 5: all-zero pass
    expect_rows(0, 0);
    pass_same(0, 0, 1);
    chk("t5_full", int'(full), 1);
    drain_wait("t5");

    // 6: clear during an accumulating pass, then reset mid-drain
    pass_same(100, 100, 0);
    beat(50, 50, 0); beat(50, 50, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("t6_clear_in_ready", int'(in_ready), 1);
    chk("t6_clear_full", int'(full), 0);
    q.push_back('{0, 1, 2}); q.push_back('{1, 3, 4});
    q.push_back('{2, 5, 6}); q.push_back('{3, 7, 8});
    beat(1, 2, 0); beat(3, 4, 0); beat(5, 6, 0); beat(7, 8, 1);
    drain_wait("t6a");
    out_ready = 1'b0;
    pass_same(9, 9, 1);
    chk("t6_full_before_rst", int'(full), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("t6_rst_in_ready", int'(in_ready), 1);
    chk("t6_rst_out_valid", int'(out_valid), 0);
    out_ready = 1'b1;
    expect_rows(-4, 6);
    pass_same(-4, 6, 1);
    drain_wait("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
